// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction memory write port and core control of the loader.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_rx_ready;
  logic                  o_imem_we;
  logic [ADDR_WIDTH-1:0] o_imem_addr;
  logic [DATA_WIDTH-1:0] o_imem_wdata;
  logic                  o_core_rst_n;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  // The loader is the master: it drives the memory port and the core reset.
  modport master (
    input  i_rx_data, i_rx_valid,
    output o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata,
    output o_core_rst_n, o_busy, o_done, o_error
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata,
    input  o_core_rst_n, o_busy, o_done, o_error
  );

endinterface

// File: rtl/imem_loader.sv
// Receives a framed byte stream, writes little-endian words into instruction
// memory and releases the core from reset only after a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input logic           i_clk,
  input logic           i_rst_n,
  imem_loader_if.master bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q;
  logic [1:0]            byte_idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            words_left_q;
  logic [7:0]            chk_q;
  logic                  core_rst_n_q;
  logic                  error_q;
  logic                  done_q;
  logic                  accept;

  assign accept = bus.i_rx_valid && bus.o_rx_ready;

  // Handshake and status are decoded from state alone, so rx inputs never
  // reach an output combinationally.
  assign bus.o_rx_ready   = (state_q != WRITE);
  assign bus.o_imem_we    = (state_q == WRITE);
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = word_q;
  assign bus.o_core_rst_n = core_rst_n_q;
  assign bus.o_done       = done_q;
  assign bus.o_error      = error_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d is assigned before the case so no path leaves it unassigned;
  // otherwise synthesis infers a latch to hold the previous value.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && bus.i_rx_data == SYNC_BYTE) state_d = COUNT;
      COUNT:   if (accept) state_d = DATA;
      DATA:    if (accept && byte_idx_q == 2'd3) state_d = WRITE;
      WRITE:   state_d = (words_left_q == 8'd0) ? CHECK : DATA;
      CHECK:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_q       <= '0;
      byte_idx_q   <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      chk_q        <= '0;
      core_rst_n_q <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && bus.i_rx_data == SYNC_BYTE) begin
            core_rst_n_q <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            chk_q        <= '0;
            byte_idx_q   <= '0;
          end
        end
        COUNT: begin
          if (accept) words_left_q <= bus.i_rx_data;
        end
        DATA: begin
          // Shift right so the first byte of a group ends up in bits [7:0].
          if (accept) begin
            word_q     <= {bus.i_rx_data, word_q[DATA_WIDTH-1:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            chk_q      <= chk_q ^ bus.i_rx_data;
          end
        end
        WRITE: begin
          addr_q       <= addr_q + 1'b1;
          words_left_q <= words_left_q - 8'd1;
        end
        CHECK: begin
          if (accept) begin
            if (bus.i_rx_data == chk_q) begin
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              error_q      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RISC-V processor. It writes the instruction memory that the core reads, receiving a framed byte stream from the serial receiver and assembling little-endian 32-bit words. It writes each word through the instruction memory write port at consecutive word addresses. The core is held in reset until a frame loads with a correct checksum.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width (fixed at 4 bytes).
- ADDR_WIDTH, 8, word-address width of instruction memory (256 words).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rx_data  input  8  incoming byte.
- i_rx_valid  input  1  i_rx_data valid.
- o_rx_ready  output  1  loader accepts byte; transfer when i_rx_valid && o_rx_ready.
- o_imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- o_imem_addr  output  ADDR_WIDTH  word address of write.
- o_imem_wdata  output  DATA_WIDTH  word to write.
- o_core_rst_n  output  1  active-low reset to the core; low while loading or after a failed load.
- o_busy  output  1  frame in progress (any state except IDLE).
- o_done  output  1  one-cycle pulse on successful load.
- o_error  output  1  sticky checksum failure flag.

## Operation
- Frame: SYNC_BYTE, COUNT (number of words minus 1, 0..255), 4*(COUNT+1) payload bytes, CHK.
- CHK is the XOR of all payload bytes only. SYNC and COUNT are excluded.
- Payload bytes are little-endian: the first byte of each group goes to bits [7:0], the fourth to [31:24].
- FSM states:
  - IDLE: non-sync bytes are discarded. SYNC_BYTE goes to COUNT, drives o_core_rst_n=0, clears o_error, address=0, checksum=0.
  - COUNT: latch the byte as remaining-words count, then go to DATA.
  - DATA: accept bytes and shift into the word register. Byte index 0..3 is a 2-bit counter. After the 4th byte, go to WRITE.
  - WRITE: o_imem_we=1 for this cycle only, o_rx_ready=0. Address increments after the write. If this was the last word, go to CHECK, else go to DATA.
  - CHECK: accept one byte. On a match, pulse o_done and go to IDLE with o_core_rst_n=1 from the next cycle. On a mismatch, set o_error, keep o_core_rst_n=0, and go to IDLE.
- Once the frame has started, a SYNC_BYTE value inside COUNT, DATA or CHECK is ordinary data.
- The address counter is ADDR_WIDTH bits and wraps modulo 2**ADDR_WIDTH. If COUNT+1 exceeds depth, later words overwrite from address 0.
- Memory writes are not rolled back on a checksum failure. The core stays in reset, so no bad code executes.
- A new frame after a success or an error starts a fresh load.

## Timing
- Reset values: state IDLE, o_rx_ready=1, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_core_rst_n=0, o_busy=0, o_done=0, o_error=0.
- All outputs are registered or decoded from state only. There is no combinational path from i_rx_* to outputs.
- o_rx_ready=1 in every state except WRITE.
- Write latency: o_imem_we rises on the cycle after the 4th byte of a word is accepted. Address and data are stable during that cycle.
- Minimum frame duration at back-to-back valid: 3 + 5*(COUNT+1) cycles.
- o_done and o_core_rst_n rising occur on the cycle after CHK is accepted.
- i_rx_valid low stalls any state without state change.
- A reset mid-frame aborts the load immediately. No partial write is issued after reset deasserts.

## Structure
- Package imem_loader_pkg holds the state enum typedef (IDLE, COUNT, DATA, WRITE, CHECK) and the default SYNC_BYTE constant.
- Single module; no sub-module. The word shift register, byte index, address counter, word counter and checksum register are inline.
- Write port signals connect to a write port added to instruction memory.

## Test plan
- Frame A5,00,13,00,00,00,CHK=13 -> one write addr 0 data 0x00000013, o_done pulse, o_core_rst_n=1, o_error=0.
- Frame A5,01 with words 0x00500093, 0x00100113, correct CHK -> writes at addr 0 then 1, o_rx_ready low exactly two single cycles.
- Same frame with CHK corrupted -> both writes occur, o_error=1 sticky, o_core_rst_n stays 0, no o_done.
- Bytes 00,FF before A5, plus a payload byte equal to A5 -> leading bytes ignored, payload A5 written as data, load succeeds.
- i_rx_valid toggled every other cycle -> same writes and data as back-to-back; i_rst_n pulsed mid-DATA -> all outputs at reset values, no write, next full frame succeeds.
- ADDR_WIDTH=2 with COUNT=4 (5 words) -> 5th word written at addr 0.
